match_ctrl_array: RTL and testbench

- Multi-channel, parametrised successor of the single-channel match/halt controller.
- Runs CHANNELS independent per-channel FSMs (IDLE/ARM/MATCH/HALT) with a match debounce, per-channel halt plus a global halt, and a saturating per-channel match-cycle counter.
- Sits between the comparator/flag logic and downstream counting/status logic; drives per-channel enable_count and aggregate status.

---
 rtl/match_ctrl_array.sv | 182 ++++++++++++++++++
 tb/tb_match_ctrl_array.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/match_ctrl_array.sv
`default_nettype none
// ============================================================================
//  Module   : match_ctrl_array
//  Purpose  : Multi-channel match/halt controller. Each channel runs an
//             IDLE/ARM/MATCH/HALT FSM that debounces match_flag for HOLD
//             sampled cycles, honours a per-channel or global halt (halt
//             beats match in every state) and counts MATCH cycles in a
//             saturating counter.
//  Revision : 1.0  initial multi-channel release
// ----------------------------------------------------------------------------
//  Ports
//    clk           in   rising-edge clock
//    reset         in   asynchronous active-low reset, synchronous release
//    match_flag    in   [CHANNELS]        per-channel match request
//    halt_flag     in   [CHANNELS]        per-channel halt request
//    global_halt   in   1                 halt applied to all channels
//    count_clr     in   1                 synchronous clear of all counters
//    state         out  [2*CHANNELS]      channel i at [2i+1:2i]
//                                         (IDLE=00 MATCH=01 HALT=10 ARM=11)
//    enable_count  out  [CHANNELS]        channel i is in MATCH
//    count         out  [CNT_W*CHANNELS]  channel i at [CNT_W*i +: CNT_W]
//    any_match     out  1                 some channel is in MATCH
//    all_halted    out  1                 every channel is in HALT
//    sat_flag      out  [CHANNELS]        sticky "counter reached max"
//                                         (only with MATCH_CTRL_SAT_FLAG_EN)
//  Build option
//    MATCH_CTRL_SAT_FLAG_EN : adds the sat_flag output and its logic.
// ============================================================================
module match_ctrl_array #(
    parameter int CHANNELS = 4,
    parameter int CNT_W    = 8,
    parameter int HOLD     = 2
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CHANNELS-1:0]       match_flag,
    input  logic [CHANNELS-1:0]       halt_flag,
    input  logic                      global_halt,
    input  logic                      count_clr,
    output logic [2*CHANNELS-1:0]     state,
    output logic [CHANNELS-1:0]       enable_count,
    output logic [CNT_W*CHANNELS-1:0] count,
    output logic                      any_match,
`ifdef MATCH_CTRL_SAT_FLAG_EN
    output logic [CHANNELS-1:0]       sat_flag,
`endif
    output logic                      all_halted
);

    localparam logic [1:0] c_idle  = 2'b00;
    localparam logic [1:0] c_match = 2'b01;
    localparam logic [1:0] c_halt  = 2'b10;
    localparam logic [1:0] c_arm   = 2'b11;

    localparam int c_hcnt_w = $clog2(HOLD + 1);
    localparam logic [c_hcnt_w-1:0] c_hcnt_one  = c_hcnt_w'(1);
    localparam logic [c_hcnt_w-1:0] c_hold_last = c_hcnt_w'(HOLD - 1);

    localparam logic [CNT_W-1:0] c_cnt_one = CNT_W'(1);
    localparam logic [CNT_W-1:0] c_cnt_max = {CNT_W{1'b1}};

    logic [CHANNELS-1:0] w_halted_vec;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_chan
        logic [1:0]          r_state;
        logic [1:0]          w_state_next;
        logic [c_hcnt_w-1:0] r_hcnt;
        logic [c_hcnt_w-1:0] w_hcnt_next;
        logic [CNT_W-1:0]    r_count;
        logic                w_halt;
        logic                w_match;
        logic                w_en;
        logic                w_halted;

        assign w_halt  = halt_flag[i] | global_halt;
        assign w_match = match_flag[i];

        // State register
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_state <= c_idle;
                r_hcnt  <= '0;
            end else begin
                r_state <= w_state_next;
                r_hcnt  <= w_hcnt_next;
            end
        end

        // Next-state logic. The hold counter only carries meaning while in
        // ARM, so every path that does not stay in or enter ARM clears it.
        always_comb begin
            w_state_next = r_state;
            w_hcnt_next  = '0;
            case (r_state)
                c_idle: begin
                    if (w_halt) begin
                        w_state_next = c_halt;
                    end else if (w_match) begin
                        if (HOLD == 1) begin
                            w_state_next = c_match;
                        end else begin
                            w_state_next = c_arm;
                            w_hcnt_next  = c_hcnt_one;
                        end
                    end
                end
                c_arm: begin
                    if (w_halt) begin
                        w_state_next = c_halt;
                    end else if (!w_match) begin
                        w_state_next = c_idle;
                    end else if (r_hcnt == c_hold_last) begin
                        w_state_next = c_match;
                    end else begin
                        w_hcnt_next = r_hcnt + c_hcnt_one;
                    end
                end
                c_match: begin
                    if (w_halt) begin
                        w_state_next = c_halt;
                    end else if (!w_match) begin
                        w_state_next = c_idle;
                    end
                end
                c_halt: begin
                    // Leaving HALT always passes through IDLE so a match
                    // must re-qualify for the full HOLD window.
                    if (!w_halt) begin
                        w_state_next = c_idle;
                    end
                end
                default: begin
                    w_state_next = c_idle;
                end
            endcase
        end

        // Output decode of the registered state
        always_comb begin
            w_en     = (r_state == c_match);
            w_halted = (r_state == c_halt);
        end

        // Saturating MATCH-cycle counter; clear wins over increment
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_count <= '0;
            end else if (count_clr) begin
                r_count <= '0;
            end else if (w_en && (r_count != c_cnt_max)) begin
                r_count <= r_count + c_cnt_one;
            end
        end

`ifdef MATCH_CTRL_SAT_FLAG_EN
        logic r_sat;

        // Set on the increment that lands on the maximum; sticky until clear
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                r_sat <= 1'b0;
            end else if (count_clr) begin
                r_sat <= 1'b0;
            end else if (w_en && (r_count == (c_cnt_max - c_cnt_one))) begin
                r_sat <= 1'b1;
            end
        end

        assign sat_flag[i] = r_sat;
`endif

        assign state[2*i +: 2]         = r_state;
        assign count[CNT_W*i +: CNT_W] = r_count;
        assign enable_count[i]         = w_en;
        assign w_halted_vec[i]         = w_halted;
    end

    assign any_match  = |enable_count;
    assign all_halted = &w_halted_vec;

endmodule
`default_nettype wire

// File: tb/tb_match_ctrl_array.sv
`default_nettype none
// ============================================================================
//  Module   : tb_match_ctrl_array
//  Purpose  : Scoreboard bench for match_ctrl_array (CHANNELS=4, CNT_W=4,
//             HOLD=2). A driver applies directed and random stimulus, steps a
//             streak-based reference model and queues the expected outputs;
//             a monitor pops and compares after every clock edge.
//  Revision : 1.0  initial release
// ============================================================================
module tb_match_ctrl_array;

    localparam int CH   = 4;
    localparam int CW   = 4;
    localparam int HOLD = 2;
    localparam int MAXC = (1 << CW) - 1;

    logic              clk = 1'b0;
    logic              reset;
    logic [CH-1:0]     match_flag;
    logic [CH-1:0]     halt_flag;
    logic              global_halt;
    logic              count_clr;
    logic [2*CH-1:0]   state;
    logic [CH-1:0]     enable_count;
    logic [CW*CH-1:0]  count;
    logic              any_match;
    logic              all_halted;
`ifdef MATCH_CTRL_SAT_FLAG_EN
    logic [CH-1:0]     sat_flag;
`endif

    match_ctrl_array #(.CHANNELS(CH), .CNT_W(CW), .HOLD(HOLD)) dut (
        .clk          (clk),
        .reset        (reset),
        .match_flag   (match_flag),
        .halt_flag    (halt_flag),
        .global_halt  (global_halt),
        .count_clr    (count_clr),
        .state        (state),
        .enable_count (enable_count),
        .count        (count),
        .any_match    (any_match),
`ifdef MATCH_CTRL_SAT_FLAG_EN
        .sat_flag     (sat_flag),
`endif
        .all_halted   (all_halted)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2*CH-1:0]  st;
        logic [CH-1:0]    en;
        logic [CW*CH-1:0] cnt;
        logic             any;
        logic             allh;
        logic [CH-1:0]    sat;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: a channel is described by whether it is halted and
    // how many consecutive un-halted cycles match has been sampled high.
    bit m_halted[CH];
    int m_streak[CH];
    int m_count[CH];
    bit m_sat[CH];

    function automatic logic [1:0] m_state(int i);
        if (m_halted[i])            return 2'b10;  // HALT
        else if (m_streak[i] == 0)  return 2'b00;  // IDLE
        else if (m_streak[i] >= HOLD) return 2'b01; // MATCH
        else                        return 2'b11;  // ARM
    endfunction

    task automatic model_reset();
        for (int i = 0; i < CH; i++) begin
            m_halted[i] = 0; m_streak[i] = 0; m_count[i] = 0; m_sat[i] = 0;
        end
    endtask

    function automatic exp_t model_outputs();
        exp_t e;
        e.allh = 1'b1;
        for (int i = 0; i < CH; i++) begin
            e.st[2*i +: 2]   = m_state(i);
            e.en[i]          = (m_state(i) == 2'b01);
            e.cnt[CW*i +: CW] = CW'(m_count[i]);
            e.sat[i]         = m_sat[i];
            if (!m_halted[i]) e.allh = 1'b0;
        end
        e.any = |e.en;
        return e;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, req, $time);
        end
    endtask

    // Drive one cycle of stimulus, advance the model across the coming edge
    // and queue what the DUT must show after it.
    task automatic step(input logic [CH-1:0] mf, input logic [CH-1:0] hf,
                        input logic gh, input logic clr);
        bit in_match;
        @(negedge clk);
        match_flag = mf; halt_flag = hf; global_halt = gh; count_clr = clr;
        for (int i = 0; i < CH; i++) begin
            in_match = (m_state(i) == 2'b01);
            if (clr) begin
                m_count[i] = 0; m_sat[i] = 0;
            end else if (in_match && m_count[i] < MAXC) begin
                m_count[i]++;
                if (m_count[i] == MAXC) m_sat[i] = 1;
            end
            if (hf[i] || gh) begin
                m_halted[i] = 1; m_streak[i] = 0;
            end else if (m_halted[i]) begin
                m_halted[i] = 0; m_streak[i] = 0;
            end else if (mf[i]) begin
                if (m_streak[i] < HOLD) m_streak[i]++;
            end else begin
                m_streak[i] = 0;
            end
        end
        sb.push_back(model_outputs());
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk("state",        32'(state),        32'(e.st));
                chk("enable_count", 32'(enable_count), 32'(e.en));
                chk("count",        32'(count),        32'(e.cnt));
                chk("any_match",    32'(any_match),    32'(e.any));
                chk("all_halted",   32'(all_halted),   32'(e.allh));
`ifdef MATCH_CTRL_SAT_FLAG_EN
                chk("sat_flag",     32'(sat_flag),     32'(e.sat));
`endif
            end
        end
    end

    task automatic drain();
        for (int k = 0; k < 20 && sb.size() > 0; k++) @(posedge clk);
        #2;
        if (sb.size() != 0) chk("scoreboard_drain", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        logic [CH-1:0] rm, rh;
        reset = 1'b0; match_flag = '0; halt_flag = '0;
        global_halt = 1'b0; count_clr = 1'b0;
        model_reset();

        #3;
        chk("reset_state",   32'(state),        32'd0);
        chk("reset_count",   32'(count),        32'd0);
        chk("reset_en",      32'(enable_count), 32'd0);
        chk("reset_any",     32'(any_match),    32'd0);
        chk("reset_allhalt", 32'(all_halted),   32'd0);

        repeat (2) @(negedge clk);
        reset = 1'b1;

        // Idle after reset release
        repeat (5) step('0, '0, 1'b0, 1'b0);

        // Channel 0 held matching: ARM, MATCH, then counter saturates
        repeat (20) step(4'b0001, '0, 1'b0, 1'b0);

        // Channel 1 single-cycle pulse: ARM then back to IDLE
        step(4'b0011, '0, 1'b0, 1'b0);
        repeat (3) step(4'b0001, '0, 1'b0, 1'b0);

        // Channel 2: reach MATCH, count a few, halt, release with match high
        repeat (7) step(4'b0101, '0, 1'b0, 1'b0);
        repeat (2) step(4'b0101, 4'b0100, 1'b0, 1'b0);
        repeat (4) step(4'b0101, '0, 1'b0, 1'b0);

        // Mixed states, then global halt with a simultaneous counter clear
        step(4'b0001, 4'b1000, 1'b0, 1'b0);
        step(4'b0011, 4'b1000, 1'b0, 1'b0);
        step(4'b0011, 4'b1000, 1'b1, 1'b1);
        step(4'b0011, 4'b0000, 1'b1, 1'b0);
        repeat (2) step('0, '0, 1'b0, 1'b0);

        // Randomized traffic, biased toward sustained matches
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < CH; i++) begin
                rm[i] = ($urandom_range(0, 99) < 75);
                rh[i] = ($urandom_range(0, 99) < 6);
            end
            step(rm, rh, ($urandom_range(0, 99) < 3), ($urandom_range(0, 99) < 4));
        end

        // Build up MATCH with nonzero counts, then reset between edges
        repeat (6) step('1, '0, 1'b0, 1'b0);
        drain();
        chk("pre_reset_any", 32'(any_match), 32'd1);
        #1;
        reset = 1'b0;
        match_flag = '0; halt_flag = '0; global_halt = 1'b0; count_clr = 1'b0;
        #1;
        chk("async_reset_state", 32'(state),        32'd0);
        chk("async_reset_count", 32'(count),        32'd0);
        chk("async_reset_en",    32'(enable_count), 32'd0);
        chk("async_reset_any",   32'(any_match),    32'd0);
`ifdef MATCH_CTRL_SAT_FLAG_EN
        chk("async_reset_sat",   32'(sat_flag),     32'd0);
`endif
        model_reset();
        @(negedge clk);
        reset = 1'b1;
        repeat (4) step(4'b0010, '0, 1'b0, 1'b0);
        drain();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
